data_sram_arbiter: RTL and testbench

- Shares one single-port 32x1024 data SRAM (active-low CEN/WEN, 1-cycle read latency, no byte enables) between two req/gnt/rvalid requesters: port 0 is the core LSU, port 1 is the FPU load/store unit.
- Arbitrates round-robin between the two ports.
- Issues SRAM strobes for each granted access.
- Converts byte-enabled partial writes into a read-modify-write (RMW) sequence.

---
 rtl/data_sram_arbiter.sv | 146 ++++++++++++++
 tb/tb_data_sram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_arbiter.sv
// Round-robin arbiter sharing one single-port data SRAM between the core LSU (port 0)
// and the FPU LSU (port 1); partial byte writes become a read-modify-write pair.
module data_sram_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIRST_PRIO = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_i,
  input  logic [1:0]          we_i,
  input  logic [DATA_W/8-1:0] be0_i,
  input  logic [DATA_W/8-1:0] be1_i,
  input  logic [ADDR_W-1:0]   addr0_i,
  input  logic [ADDR_W-1:0]   addr1_i,
  input  logic [DATA_W-1:0]   wdata0_i,
  input  logic [DATA_W-1:0]   wdata1_i,
  output logic [1:0]          gnt_o,
  output logic [1:0]          rvalid_o,
  output logic [DATA_W-1:0]   rdata0_o,
  output logic [DATA_W-1:0]   rdata1_o,
  output logic                sram_cen,
  output logic                sram_wen,
  output logic [ADDR_W-1:0]   sram_a,
  output logic [DATA_W-1:0]   sram_d,
  input  logic [DATA_W-1:0]   sram_q
);

  localparam int NB = DATA_W / 8;

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t            state_reg;
  logic              last_grant_reg;
  logic              rmw_port_reg;
  logic [ADDR_W-1:0] rmw_addr_reg;
  logic [NB-1:0]     rmw_be_reg;
  logic [DATA_W-1:0] rmw_wdata_reg;
  logic              rsp_valid_reg;
  logic              rsp_port_reg;
  logic              rsp_is_read_reg;
  logic [ADDR_W-1:0] a_hold_reg;
  logic [DATA_W-1:0] d_hold_reg;

  logic [1:0]        req_ok;
  logic              gnt_any;
  logic              gnt_port;
  logic              sel_we;
  logic [NB-1:0]     sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              is_empty;
  logic              is_partial;
  logic [DATA_W-1:0] merged_d;

  // Requests are only considered in IDLE and never while reset is held.
  assign req_ok   = (state_reg == IDLE && !rst) ? req_i : 2'b00;
  assign gnt_any  = |req_ok;
  assign gnt_port = (&req_ok) ? ~last_grant_reg : req_ok[1];
  assign gnt_o    = gnt_any ? (gnt_port ? 2'b10 : 2'b01) : 2'b00;

  assign sel_we     = we_i[gnt_port];
  assign sel_be     = gnt_port ? be1_i    : be0_i;
  assign sel_addr   = gnt_port ? addr1_i  : addr0_i;
  assign sel_wdata  = gnt_port ? wdata1_i : wdata0_i;
  assign is_empty   = sel_we && (sel_be == '0);
  assign is_partial = sel_we && (sel_be != '0) && (sel_be != {NB{1'b1}});

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_merge
      assign merged_d[8*gi +: 8] = rmw_be_reg[gi] ? rmw_wdata_reg[8*gi +: 8] : sram_q[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    sram_a   = a_hold_reg;
    sram_d   = d_hold_reg;
    if (state_reg == RMW_WR && !rst) begin
      sram_cen = 1'b0;
      sram_wen = 1'b0;
      sram_a   = rmw_addr_reg;
      sram_d   = merged_d;
    end else if (gnt_any && !is_empty) begin
      // A partial write starts with a plain read of the target word.
      sram_cen = 1'b0;
      sram_wen = ~(sel_we && !is_partial);
      sram_a   = sel_addr;
      sram_d   = sel_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      last_grant_reg  <= (FIRST_PRIO == 0);
      rmw_port_reg    <= 1'b0;
      rmw_addr_reg    <= '0;
      rmw_be_reg      <= '0;
      rmw_wdata_reg   <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_port_reg    <= 1'b0;
      rsp_is_read_reg <= 1'b0;
      a_hold_reg      <= '0;
      d_hold_reg      <= '0;
    end else begin
      if (!sram_cen) begin
        a_hold_reg <= sram_a;
        d_hold_reg <= sram_d;
      end
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (gnt_any) begin
            last_grant_reg <= gnt_port;
            if (is_partial) begin
              rmw_port_reg  <= gnt_port;
              rmw_addr_reg  <= sel_addr;
              rmw_be_reg    <= sel_be;
              rmw_wdata_reg <= sel_wdata;
              state_reg     <= RMW_WR;
            end else begin
              rsp_valid_reg   <= 1'b1;
              rsp_port_reg    <= gnt_port;
              rsp_is_read_reg <= ~sel_we;
            end
          end
        end
        RMW_WR: begin
          rsp_valid_reg   <= 1'b1;
          rsp_port_reg    <= rmw_port_reg;
          rsp_is_read_reg <= 1'b0;
          state_reg       <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rvalid_o = rsp_valid_reg ? (rsp_port_reg ? 2'b10 : 2'b01) : 2'b00;
  assign rdata0_o = (rvalid_o[0] && rsp_is_read_reg) ? sram_q : '0;
  assign rdata1_o = (rvalid_o[1] && rsp_is_read_reg) ? sram_q : '0;

endmodule

// File: tb/tb_data_sram_arbiter.sv
// Self-checking bench for data_sram_arbiter: a reference model predicts grants and SRAM
// strobes each cycle, and a scoreboard matches every response against its grant.
module tb_data_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_i = '0, we_i = '0;
  logic [3:0]  be0_i = '0, be1_i = '0;
  logic [9:0]  addr0_i = '0, addr1_i = '0;
  logic [31:0] wdata0_i = '0, wdata1_i = '0;
  logic [1:0]  gnt_o, rvalid_o;
  logic [31:0] rdata0_o, rdata1_o;
  logic        sram_cen, sram_wen;
  logic [9:0]  sram_a;
  logic [31:0] sram_d;
  logic [31:0] sram_q = '0;

  always #5 clk = ~clk;

  data_sram_arbiter dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .be0_i(be0_i), .be1_i(be1_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata0_o(rdata0_o), .rdata1_o(rdata1_o),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a), .sram_d(sram_d),
    .sram_q(sram_q)
  );

  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];

  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) mem[sram_a] <= sram_d;
      sram_q <= mem[sram_a];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  logic        m_last = 1'b1;
  logic        m_rmw = 1'b0;
  logic [9:0]  m_rmw_addr = '0;
  logic [31:0] m_rmw_d = '0, m_rmw_old = '0;
  logic [9:0]  m_ah = '0;
  logic [31:0] m_dh = '0;

  task automatic set_in(input logic [1:0] r, input logic [1:0] w, input logic [3:0] b0,
                        input logic [3:0] b1, input logic [9:0] a0, input logic [9:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
    req_i = r; we_i = w; be0_i = b0; be1_i = b1;
    addr0_i = a0; addr1_i = a1; wdata0_i = d0; wdata1_i = d1;
  endtask

  // One clock of model prediction and checking, then advance to just after the next edge.
  task automatic step(output logic [1:0] g);
    logic [1:0]  eg;
    logic        p, sw, ecen, ewen;
    logic [3:0]  sb;
    logic [9:0]  sa, ea;
    logic [31:0] sd, ed, old, mg;
    #1;
    if (rst) begin
      if (m_rmw) ref_mem[m_rmw_addr] = m_rmw_old;
      m_rmw = 1'b0; m_last = 1'b1; m_ah = '0; m_dh = '0;
      sbq.delete();
      chk("rst_gnt", gnt_o, 2'b00);
      chk("rst_cen", sram_cen, 1'b1);
      chk("rst_wen", sram_wen, 1'b1);
      chk("rst_a", sram_a, 10'h0);
      chk("rst_d", sram_d, 32'h0);
      g = 2'b00;
    end else begin
      if (m_rmw) eg = 2'b00;
      else if (req_i == 2'b11) eg = m_last ? 2'b01 : 2'b10;
      else eg = req_i;
      p  = eg[1];
      sw = we_i[p];
      sb = p ? be1_i : be0_i;
      sa = p ? addr1_i : addr0_i;
      sd = p ? wdata1_i : wdata0_i;
      ecen = 1'b1; ewen = 1'b1; ea = m_ah; ed = m_dh;
      if (m_rmw) begin
        ecen = 1'b0; ewen = 1'b0; ea = m_rmw_addr; ed = m_rmw_d;
      end else if (eg != 2'b00 && !(sw && sb == 4'h0)) begin
        ecen = 1'b0; ewen = !(sw && sb == 4'hF); ea = sa; ed = sd;
      end
      chk("gnt", gnt_o, eg);
      chk("sram_cen", sram_cen, ecen);
      chk("sram_wen", sram_wen, ewen);
      chk("sram_a", sram_a, ea);
      chk("sram_d", sram_d, ed);
      if (!ecen) begin m_ah = ea; m_dh = ed; end
      if (m_rmw) begin
        m_rmw = 1'b0;
      end else if (eg != 2'b00) begin
        m_last = p;
        old = ref_mem[sa];
        if (!sw) sbq.push_back('{p, old, cyc + 1});
        else if (sb == 4'hF) begin ref_mem[sa] = sd; sbq.push_back('{p, 32'h0, cyc + 1}); end
        else if (sb == 4'h0) sbq.push_back('{p, 32'h0, cyc + 1});
        else begin
          for (int k = 0; k < 4; k++) mg[8*k +: 8] = sb[k] ? sd[8*k +: 8] : old[8*k +: 8];
          m_rmw = 1'b1; m_rmw_addr = sa; m_rmw_d = mg; m_rmw_old = old;
          ref_mem[sa] = mg;
          sbq.push_back('{p, 32'h0, cyc + 2});
        end
      end
      g = eg;
    end
    @(posedge clk);
    #1;
  endtask

  // Response monitor: pops the scoreboard whenever a response is due.
  initial begin
    logic [1:0]  erv;
    logic [31:0] ed;
    forever begin
      @(posedge clk);
      #4;
      if (rst) begin
        chk("rst_rvalid", rvalid_o, 2'b00);
        chk("rst_rdata0", rdata0_o, 32'h0);
        chk("rst_rdata1", rdata1_o, 32'h0);
      end else begin
        erv = 2'b00; ed = 32'h0;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
          erv = sbq[0].port ? 2'b10 : 2'b01;
          ed  = sbq[0].data;
        end
        chk("rvalid", rvalid_o, erv);
        chk("rdata0", rdata0_o, erv[0] ? ed : 32'h0);
        chk("rdata1", rdata1_o, erv[1] ? ed : 32'h0);
        if (erv != 2'b00) begin
          $display("rsp port%0d rdata=%08h cycle %0d", sbq[0].port, rdata0_o | rdata1_o, cyc);
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    logic [1:0]  g;
    logic [31:0] keep30;
    logic [1:0]  rq;
    logic        pw [2];
    logic [3:0]  pbe [2];
    logic [9:0]  pa [2];
    logic [31:0] pd [2];

    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hA5000000 ^ (i * 32'h00010203);
      ref_mem[i] = 32'hA5000000 ^ (i * 32'h00010203);
    end
    keep30 = ref_mem[10'h030];

    set_in(2'b11, 2'b00, 4'hF, 4'hF, 10'h1, 10'h2, 32'h0, 32'h0);
    @(posedge clk); #1;
    step(g); step(g);
    rst = 1'b0;

    // Contention: both ports read every cycle, grants must alternate starting at port 0.
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("contend_gnt", gnt_o, (k % 2) ? 2'b10 : 2'b01);
      step(g);
    end
    set_in(2'b00, 2'b00, 4'h0, 4'h0, 10'h0, 10'h0, 32'h0, 32'h0);
    step(g);

    // Full write then read back.
    set_in(2'b01, 2'b01, 4'hF, 4'h0, 10'h005, 10'h0, 32'hDEADBEEF, 32'h0);
    #1; chk("wr_wen", sram_wen, 1'b0);
    step(g);
    set_in(2'b01, 2'b00, 4'h0, 4'h0, 10'h005, 10'h0, 32'h0, 32'h0);
    #1; chk("rd_gnt", gnt_o, 2'b01);
    step(g);
    set_in(2'b00, 2'b00, 4'h0, 4'h0, 10'h0, 10'h0, 32'h0, 32'h0);
    #1; chk("rd_rvalid", rvalid_o, 2'b01); chk("rd_rdata0", rdata0_o, 32'hDEADBEEF);
    step(g);

    // Partial write from port 1 becomes read then merged write.
    set_in(2'b01, 2'b01, 4'hF, 4'h0, 10'h3FF, 10'h0, 32'h11223344, 32'h0);
    step(g);
    set_in(2'b10, 2'b10, 4'h0, 4'b0101, 10'h0, 10'h3FF, 32'h0, 32'hAABBCCDD);
    #1; chk("rmw_gnt", gnt_o, 2'b10); chk("rmw_rd_wen", sram_wen, 1'b1);
    step(g);
    set_in(2'b00, 2'b00, 4'h0, 4'h0, 10'h0, 10'h0, 32'h0, 32'h0);
    #1; chk("rmw_wr_gnt", gnt_o, 2'b00); chk("rmw_wr_cen", sram_cen, 1'b0);
    chk("rmw_wr_d", sram_d, 32'h11BB33DD);
    step(g); step(g);
    set_in(2'b01, 2'b00, 4'h0, 4'h0, 10'h3FF, 10'h0, 32'h0, 32'h0);
    step(g);
    set_in(2'b00, 2'b00, 4'h0, 4'h0, 10'h0, 10'h0, 32'h0, 32'h0);
    #1; chk("rmw_readback", rdata0_o, 32'h11BB33DD);
    step(g);

    // Port 1 read is held off until the cycle after the merged write.
    set_in(2'b01, 2'b01, 4'b0011, 4'h0, 10'h020, 10'h021, 32'h12345678, 32'h0);
    #1; chk("blk_gnt0", gnt_o, 2'b01);
    step(g);
    set_in(2'b10, 2'b00, 4'h0, 4'h0, 10'h0, 10'h021, 32'h0, 32'h0);
    #1; chk("blk_wr_gnt", gnt_o, 2'b00);
    step(g);
    #1; chk("blk_gnt1", gnt_o, 2'b10); chk("blk_rvalid", rvalid_o, 2'b01);
    step(g);
    set_in(2'b00, 2'b00, 4'h0, 4'h0, 10'h0, 10'h0, 32'h0, 32'h0);
    step(g); step(g);

    // Empty write: granted, no SRAM access, word unchanged.
    set_in(2'b10, 2'b10, 4'h0, 4'h0, 10'h0, 10'h010, 32'h0, 32'hFFFFFFFF);
    #1; chk("empty_gnt", gnt_o, 2'b10); chk("empty_cen", sram_cen, 1'b1);
    step(g);
    set_in(2'b10, 2'b00, 4'h0, 4'h0, 10'h0, 10'h010, 32'h0, 32'h0);
    #1; chk("empty_rvalid", rvalid_o, 2'b10);
    step(g);
    set_in(2'b00, 2'b00, 4'h0, 4'h0, 10'h0, 10'h0, 32'h0, 32'h0);
    step(g);

    // Reset during the merged write cycle.
    set_in(2'b01, 2'b01, 4'b1000, 4'h0, 10'h030, 10'h0, 32'hCAFEBABE, 32'h0);
    step(g);
    set_in(2'b00, 2'b00, 4'h0, 4'h0, 10'h0, 10'h0, 32'h0, 32'h0);
    rst = 1'b1;
    #1; chk("rstmid_cen", sram_cen, 1'b1); chk("rstmid_rvalid", rvalid_o, 2'b00);
    step(g); step(g);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step(g);
    chk("rstmid_word", mem[10'h030], keep30);
    set_in(2'b01, 2'b00, 4'h0, 4'h0, 10'h030, 10'h0, 32'h0, 32'h0);
    step(g);
    set_in(2'b00, 2'b00, 4'h0, 4'h0, 10'h0, 10'h0, 32'h0, 32'h0);
    step(g);

    // Random mixed traffic; requesters hold their request until granted.
    rq = 2'b00;
    for (int p = 0; p < 2; p++) begin pw[p] = 1'b0; pbe[p] = 4'h0; pa[p] = '0; pd[p] = '0; end
    for (int n = 0; n < 80; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rq[p] || g[p]) begin
          rq[p]  = ($urandom_range(0, 3) != 0);
          pw[p]  = $urandom_range(0, 1);
          case ($urandom_range(0, 3))
            0: pbe[p] = 4'h0;
            1: pbe[p] = 4'hF;
            default: pbe[p] = 4'($urandom_range(1, 14));
          endcase
          pa[p] = 10'($urandom_range(0, 15));
          pd[p] = $urandom;
        end
      end
      set_in(rq, {pw[1], pw[0]}, pbe[0], pbe[1], pa[0], pa[1], pd[0], pd[1]);
      step(g);
    end
    set_in(2'b00, 2'b00, 4'h0, 4'h0, 10'h0, 10'h0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) step(g);
    chk("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
